// File: rtl/cal_pkg.sv
// Shared constants, state and byte-class types for the calculator command parser.
package cal_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int MAX_DIGITS_DEF = 5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;

    typedef enum logic [1:0] {
        S_SRC1 = 2'd0,
        S_SRC2 = 2'd1,
        S_ERR  = 2'd2,
        S_DONE = 2'd3
    } parser_state_e;

    typedef enum logic [2:0] {
        C_DIGIT   = 3'd0,
        C_OP      = 3'd1,
        C_TERM    = 3'd2,
        C_SPACE   = 3'd3,
        C_ILLEGAL = 3'd4
    } byte_class_e;

    function automatic byte_class_e classify(input logic [7:0] b);
        byte_class_e cls;
        if (b >= ASCII_0 && b <= ASCII_9)
            cls = C_DIGIT;
        else if (b == ASCII_PLUS || b == ASCII_MINUS || b == ASCII_STAR || b == ASCII_SLASH)
            cls = C_OP;
        else if (b == ASCII_CR || b == ASCII_EQ)
            cls = C_TERM;
        else if (b == ASCII_SP)
            cls = C_SPACE;
        else
            cls = C_ILLEGAL;
        return cls;
    endfunction

    function automatic logic [1:0] op_code(input logic [7:0] b);
        logic [1:0] code;
        case (b)
            ASCII_MINUS: code = OP_SUB;
            ASCII_STAR:  code = OP_MUL;
            ASCII_SLASH: code = OP_DIV;
            default:     code = OP_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/dec_mac10.sv
// Decimal accumulator: acc <= acc*10 + digit with a digit counter and a sticky
// overflow flag; the value saturates at all-ones once overflow has been seen.
module dec_mac10 #(
    parameter int DATA_W     = cal_pkg::DATA_W_DEF,
    parameter int MAX_DIGITS = cal_pkg::MAX_DIGITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        digit,
    input  logic              valid,
    input  logic              clr_acc,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] acc,
    output logic              has_digits,
    output logic              ovf
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(MAX_DIGITS + 1);
    localparam logic [DATA_W+3:0] ACC_MAX = {4'b0000, {DATA_W{1'b1}}};

    logic [DATA_W-1:0] acc_reg;
    logic              ovf_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W+3:0] acc_wide;
    logic [DATA_W+3:0] prod_next;
    logic              sat_next;

    // Four guard bits hold 10*(2^DATA_W-1)+9 without wrapping.
    assign acc_wide  = {4'b0000, acc_reg};
    assign prod_next = (acc_wide << 3) + (acc_wide << 1) + {{DATA_W{1'b0}}, digit};
    assign cnt_next  = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;
    assign sat_next  = ovf_reg || (prod_next > ACC_MAX) || (cnt_next > CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            if (clr_acc) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else if (valid) begin
                cnt_reg <= cnt_next;
                if (sat_next) begin
                    acc_reg <= '1;
                    ovf_reg <= 1'b1;
                end else begin
                    acc_reg <= prod_next[DATA_W-1:0];
                end
            end
            if (clr_ovf)
                ovf_reg <= 1'b0;
        end
    end

    assign acc        = acc_reg;
    assign has_digits = (cnt_reg != '0);
    assign ovf        = ovf_reg;

endmodule

// File: rtl/cal_cmd_parser.sv
// Parses "<dec><op><dec><CR|=>" from the UART byte stream into two operands and an
// opcode, handing a valid command to the arithmetic units or flagging a parse error.
module cal_cmd_parser
    import cal_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              calc_ready,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic [1:0]        op,
    output logic              parser_done,
    output logic              parse_err,
    output logic              busy
);

    parser_state_e     state_reg;
    logic [DATA_W-1:0] src1_hold_reg;
    logic [1:0]        op_hold_reg;
    byte_class_e       cls;
    logic              mac_valid;
    logic              mac_clr_acc;
    logic              mac_clr_ovf;
    logic [DATA_W-1:0] mac_acc;
    logic              mac_has_digits;
    logic              mac_ovf;
    logic              check_fail;

    assign cls        = classify(rx_data);
    assign check_fail = !mac_has_digits || mac_ovf ||
                        (op_hold_reg == OP_DIV && mac_acc == '0);

    // Single accumulator: src1 is parked in src1_hold_reg at the operator, and the
    // accumulator then carries src2 until the command is handed off.
    dec_mac10 #(
        .DATA_W     (DATA_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .digit      (rx_data[3:0]),
        .valid      (mac_valid),
        .clr_acc    (mac_clr_acc),
        .clr_ovf    (mac_clr_ovf),
        .acc        (mac_acc),
        .has_digits (mac_has_digits),
        .ovf        (mac_ovf)
    );

    always_comb begin
        mac_valid   = 1'b0;
        mac_clr_acc = 1'b0;
        mac_clr_ovf = 1'b0;
        case (state_reg)
            S_SRC1: if (rx_valid) begin
                mac_valid   = (cls == C_DIGIT);
                mac_clr_acc = (cls == C_OP && mac_has_digits) || (cls == C_TERM);
                mac_clr_ovf = (cls == C_TERM);
            end
            S_SRC2: if (rx_valid) begin
                mac_valid   = (cls == C_DIGIT);
                mac_clr_acc = (cls == C_TERM) && check_fail;
                mac_clr_ovf = (cls == C_TERM) && check_fail;
            end
            S_ERR: begin
                mac_clr_acc = rx_valid && (cls == C_TERM);
                mac_clr_ovf = rx_valid && (cls == C_TERM);
            end
            S_DONE: begin
                mac_clr_acc = calc_ready;
                mac_clr_ovf = calc_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_SRC1;
            src1_hold_reg <= '0;
            op_hold_reg   <= OP_ADD;
            src1          <= '0;
            src2          <= '0;
            op            <= OP_ADD;
            parser_done   <= 1'b0;
            parse_err     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            parser_done <= 1'b0;
            parse_err   <= 1'b0;
            case (state_reg)
                S_SRC1: if (rx_valid) begin
                    case (cls)
                        C_OP: begin
                            if (mac_has_digits) begin
                                src1_hold_reg <= mac_acc;
                                op_hold_reg   <= op_code(rx_data);
                                state_reg     <= S_SRC2;
                            end else begin
                                state_reg <= S_ERR;
                            end
                        end
                        // The terminator is already consumed, so reject right away.
                        C_TERM:    parse_err <= 1'b1;
                        C_ILLEGAL: state_reg <= S_ERR;
                        default: ;
                    endcase
                end
                S_SRC2: if (rx_valid) begin
                    case (cls)
                        C_TERM: begin
                            if (check_fail) begin
                                parse_err <= 1'b1;
                                state_reg <= S_SRC1;
                            end else begin
                                busy      <= 1'b1;
                                state_reg <= S_DONE;
                            end
                        end
                        C_OP, C_ILLEGAL: state_reg <= S_ERR;
                        default: ;
                    endcase
                end
                S_ERR: if (rx_valid && cls == C_TERM) begin
                    parse_err <= 1'b1;
                    state_reg <= S_SRC1;
                end
                S_DONE: if (calc_ready) begin
                    src1        <= src1_hold_reg;
                    src2        <= mac_acc;
                    op          <= op_hold_reg;
                    parser_done <= 1'b1;
                    busy        <= 1'b0;
                    state_reg   <= S_SRC1;
                end
                default: state_reg <= S_SRC1;
            endcase
        end
    end

endmodule

// File: tb/tb_cal_cmd_parser.sv
// Bench for cal_cmd_parser: a command-level reference model evaluates each complete
// command string and every cycle's outputs are compared against it.
module tb_cal_cmd_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        calc_ready = 1'b1;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [1:0]  op;
    logic        parser_done;
    logic        parse_err;
    logic        busy;

    cal_cmd_parser #(.DATA_W(16), .MAX_DIGITS(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .calc_ready  (calc_ready),
        .src1        (src1),
        .src2        (src2),
        .op          (op),
        .parser_done (parser_done),
        .parse_err   (parse_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int err_seen = 0;

    // Reference model state: visible outputs plus the pending command.
    int m_src1 = 0, m_src2 = 0, m_op = 0;
    bit m_done = 0, m_err = 0, m_pending = 0;
    int p_a = 0, p_b = 0, p_op = 0;
    logic [7:0] cmd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int op_index(input logic [7:0] c);
        case (c)
            8'h2B:   return 0;
            8'h2D:   return 1;
            8'h2A:   return 2;
            8'h2F:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit num_ok(input int lo, input int hi, output int val);
        val = 0;
        if (hi < lo || hi - lo + 1 > 5) return 0;
        for (int i = lo; i <= hi; i++) begin
            if (cmd_q[i] < 8'h30 || cmd_q[i] > 8'h39) return 0;
            val = val * 10 + int'(cmd_q[i] - 8'h30);
        end
        return val <= 65535;
    endfunction

    // Whole-command evaluation of the buffered (space-free) bytes.
    function automatic bit parse_cmd(output int a, output int b, output int o);
        int p = -1;
        a = 0; b = 0; o = 0;
        for (int i = 0; i < cmd_q.size(); i++)
            if (p < 0 && op_index(cmd_q[i]) >= 0) p = i;
        if (p < 1) return 0;
        o = op_index(cmd_q[p]);
        if (!num_ok(0, p - 1, a)) return 0;
        if (!num_ok(p + 1, cmd_q.size() - 1, b)) return 0;
        if (o == 3 && b == 0) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        m_src1 = 0; m_src2 = 0; m_op = 0;
        m_done = 0; m_err = 0; m_pending = 0;
        cmd_q.delete();
    endtask

    task automatic model_step();
        m_done = 0;
        m_err  = 0;
        if (m_pending) begin
            if (calc_ready) begin
                m_done = 1; m_src1 = p_a; m_src2 = p_b; m_op = p_op; m_pending = 0;
            end
        end else if (rx_valid) begin
            if (rx_data == 8'h20) begin
            end else if (rx_data == 8'h0D || rx_data == 8'h3D) begin
                if (parse_cmd(p_a, p_b, p_op)) m_pending = 1;
                else m_err = 1;
                cmd_q.delete();
            end else begin
                cmd_q.push_back(rx_data);
            end
        end
    endtask

    task automatic compare_all();
        chk("src1", 32'(src1), 32'(m_src1));
        chk("src2", 32'(src2), 32'(m_src2));
        chk("op", 32'(op), 32'(m_op));
        chk("parser_done", 32'(parser_done), 32'(m_done));
        chk("parse_err", 32'(parse_err), 32'(m_err));
        chk("busy", 32'(busy), 32'(m_pending));
        if (parser_done === 1'b1) done_seen++;
        if (parse_err === 1'b1) err_seen++;
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        compare_all();
        rx_valid = v; rx_data = d; calc_ready = rdy;
        @(posedge clk);
        model_step();
    endtask

    task automatic send(input string s, input logic rdy);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h23) c = 8'h0D;
            tick(1'b1, c, rdy);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b1);
    endtask

    task automatic seg_check(input string name, input int d0, input int e0,
                             input int nd, input int ne, input int a, input int b, input int o);
        #1;
        chk({name, ".done_cnt"}, 32'(done_seen - d0), 32'(nd));
        chk({name, ".err_cnt"}, 32'(err_seen - e0), 32'(ne));
        chk({name, ".src1"}, 32'(src1), 32'(a));
        chk({name, ".src2"}, 32'(src2), 32'(b));
        chk({name, ".op"}, 32'(op), 32'(o));
        chk({name, ".model_src1"}, 32'(m_src1), 32'(a));
        chk({name, ".model_src2"}, 32'(m_src2), 32'(b));
        chk({name, ".model_op"}, 32'(m_op), 32'(o));
    endtask

    task automatic check_zero(input string name);
        chk({name, ".src1"}, 32'(src1), 32'd0);
        chk({name, ".src2"}, 32'(src2), 32'd0);
        chk({name, ".op"}, 32'(op), 32'd0);
        chk({name, ".done"}, 32'(parser_done), 32'd0);
        chk({name, ".err"}, 32'(parse_err), 32'd0);
        chk({name, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0, e0;
        model_reset();
        #1;
        check_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step();

        d0 = done_seen; e0 = err_seen;
        send("12+34#", 1'b1); idle(3);
        seg_check("add", d0, e0, 1, 0, 12, 34, 0);

        d0 = done_seen; e0 = err_seen;
        send("65535/255=", 1'b1); idle(3);
        seg_check("div_max", d0, e0, 1, 0, 65535, 255, 3);

        d0 = done_seen; e0 = err_seen;
        send("65536*2#", 1'b1); idle(3);
        seg_check("ovf_val", d0, e0, 0, 1, 65535, 255, 3);

        d0 = done_seen; e0 = err_seen;
        send("123456+1#", 1'b1); idle(3);
        seg_check("ovf_digits", d0, e0, 0, 1, 65535, 255, 3);

        d0 = done_seen; e0 = err_seen;
        send("7/0#", 1'b1); idle(3);
        seg_check("div_zero", d0, e0, 0, 1, 65535, 255, 3);

        d0 = done_seen; e0 = err_seen;
        send("7/ 0 0 1#", 1'b1); idle(3);
        seg_check("spaces", d0, e0, 1, 0, 7, 1, 3);

        d0 = done_seen; e0 = err_seen;
        send("1a+2#3*4#", 1'b1); idle(3);
        seg_check("recover", d0, e0, 1, 1, 3, 4, 2);

        d0 = done_seen; e0 = err_seen;
        send("9-8#", 1'b0);
        send("5+5#", 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 8'h00, 1'b0);
        #1;
        chk("wait.busy", 32'(busy), 32'd1);
        chk("wait.no_done", 32'(done_seen - d0), 32'd0);
        idle(3);
        seg_check("wait", d0, e0, 1, 0, 9, 8, 1);

        d0 = done_seen; e0 = err_seen;
        send("2*3#", 1'b1); idle(3);
        seg_check("after_wait", d0, e0, 1, 0, 2, 3, 2);

        send("45+", 1'b1);
        @(negedge clk);
        compare_all();
        rst = 1'b1; rx_valid = 1'b0;
        model_reset();
        #1;
        check_zero("mid_reset");
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        @(posedge clk);
        model_step();

        d0 = done_seen; e0 = err_seen;
        send("1+1#", 1'b1); idle(3);
        seg_check("post_reset", d0, e0, 1, 0, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
